switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
//  Conditions raw board slide switches (start, random-seed, etc.) before they reach the
//  control FSM. Each channel gets a 2-flop synchronizer and a counter-based debouncer.
//  Outputs are a stable level and one-cycle rise/fall pulses.
//  Sits directly upstream of the game control FSM, which consumes swLevel as
//  startSwitch/randSwitch.
// PARAMETERS
//  NUM_SW           3          number of independent switch channels
//  DEBOUNCE_CYCLES  1_000_000  cycles input must stay stable to be accepted (20 ms @ 50 MHz); >=1
//  CNT_W            20         debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES-1
// PORTS
//  clk      in   1       single system clock; all logic on posedge
//  resetN   in   1       asynchronous, active-low reset
//  swRaw    in   NUM_SW  raw asynchronous switch inputs
//  swLevel  out  NUM_SW  debounced, synchronous switch level
//  swRise   out  NUM_SW  1-cycle pulse on accepted 0->1
//  swFall   out  NUM_SW  1-cycle pulse on accepted 1->0
// BEHAVIOUR
//  - Reset (resetN=0, no clock needed): sync flops=0, all channel states=STABLE_LO,
//    counters=0, swLevel=0, swRise=0, swFall=0.
//  - Sync: swSync = swRaw delayed by 2 flops. Only swSync feeds the FSM.
//  - Per-channel FSM: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
//  - STABLE_LO: swSync=1 -> PEND_HI, count<=0. Otherwise stay.
//  - PEND_HI:
//    - swSync=0 -> STABLE_LO. This is a glitch: no pulse, count<=0.
//    - swSync=1 and count==DEBOUNCE_CYCLES-1 -> STABLE_HI, swLevel<=1, swRise<=1.
//    - swSync=1, otherwise -> count<=count+1.
//  - STABLE_HI and PEND_LO: mirror of the above with polarity swapped; acceptance sets
//    swLevel<=0, swFall<=1.
//  - All outputs are registered. swRise/swFall are high for exactly 1 cycle, in the same
//    cycle swLevel changes; otherwise 0.
//  - Latency: raw change sampled at edge 0 -> swLevel changes after edge DEBOUNCE_CYCLES+3.
//    This is 2 sync edges + 1 entry edge + DEBOUNCE_CYCLES.
//  - Any bounce inside a PEND state returns to the prior STABLE state. The full count
//    restarts on the next change. Rejected glitches produce no pulse.
//  - DEBOUNCE_CYCLES=1: PEND state lasts exactly 1 cycle; latency is 4 edges.
//  - Counter never wraps; it is compared against DEBOUNCE_CYCLES-1 and cleared on every PEND entry.
//  - Channels are fully independent. Simultaneous events on several channels pulse in the
//    same cycle.
//  - Switch held high through reset release: treated as a new 0->1. After
//    DEBOUNCE_CYCLES+3 edges, swLevel=1 and swRise pulses once.
//  - Reset asserted mid-PEND: immediate return to reset values. No partial pulse.
// STRUCTURE
//  - Shared package game_pkg:
//    - typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} dbState_t;
//    - localparam DEBOUNCE_DEFAULT = 1_000_000.
//  - Sub-module debounce_channel (clk, resetN, din, level, rise, fall), parameterized by
//    DEBOUNCE_CYCLES and CNT_W. It contains the sync flops, counter and FSM.
//  - Top is a generate loop of NUM_SW instances; no top-level logic.
// TESTING  (override DEBOUNCE_CYCLES=4, CNT_W=3)
//  1. resetN=0, swRaw=3'b111, clock running -> all outputs 0. Release, hold swRaw[0]=1
//     -> swLevel[0]=1 and swRise[0]=1 exactly 1 cycle, both after edge 7.
//  2. swRaw[1] high for 3 cycles, then low -> swLevel[1] stays 0; swRise[1] and swFall[1]
//     never assert.
//  3. swRaw[0] toggles 1,0,1,0,1 on consecutive cycles, then held 1 -> swLevel[0] rises
//     7 edges after the final 0->1; exactly one swRise.
//  4. From swLevel[2]=1, drop swRaw[2] and hold -> swLevel[2]=0 and swFall[2] 1-cycle
//     pulse, 7 edges later.
//  5. swRaw[0] and swRaw[2] rise on the same edge -> swRise[0] and swRise[2] pulse in the
//     same cycle; channel 1 unaffected.
//  6. Pull resetN low 2 cycles into PEND_HI, between clock edges -> outputs 0 with no
//     clock edge. Release -> full 7-edge latency restarts.

Source files
------------

// File: rtl/game_pkg.sv
// ============================================================================
// Module  : game_pkg
// Brief   : Shared types and defaults for the switch conditioning path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package game_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } dbState_t;

    // 20 ms at a 50 MHz system clock
    localparam int DEBOUNCE_DEFAULT = 1_000_000;

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// Module  : debounce_channel
// Brief   : One switch channel: 2-flop synchronizer, debounce counter and FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module debounce_channel
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic resetN,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    dbState_t         state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
        end
    end

    // The counter is only ever compared against c_CNT_LAST and cleared on each
    // pending entry or rejected glitch, so it never wraps.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                STABLE_LO: begin
                    if (sync2_q) begin
                        state_q <= PEND_HI;
                        cnt_q   <= '0;
                    end
                end
                PEND_HI: begin
                    if (!sync2_q) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                    end else if (cnt_q == c_CNT_LAST) begin
                        state_q <= STABLE_HI;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!sync2_q) begin
                        state_q <= PEND_LO;
                        cnt_q   <= '0;
                    end
                end
                PEND_LO: begin
                    if (sync2_q) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                    end else if (cnt_q == c_CNT_LAST) begin
                        state_q <= STABLE_LO;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= STABLE_LO;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

`default_nettype wire

// File: rtl/switch_debouncer.sv
// ============================================================================
// Module  : switch_debouncer
// Brief   : Array of independent debounced switch channels feeding the game FSM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module switch_debouncer
    import game_pkg::*;
#(
    parameter int NUM_SW          = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 20
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic [NUM_SW-1:0] swRaw,
    output logic [NUM_SW-1:0] swLevel,
    output logic [NUM_SW-1:0] swRise,
    output logic [NUM_SW-1:0] swFall
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SW; gi++) begin : g_ch
            debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_ch (
                .clk    (clk),
                .resetN (resetN),
                .din    (swRaw[gi]),
                .level  (swLevel[gi]),
                .rise   (swRise[gi]),
                .fall   (swFall[gi])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_switch_debouncer.sv
// ============================================================================
// Module  : tb_switch_debouncer
// Brief   : Directed self-checking bench for switch_debouncer (DEBOUNCE_CYCLES=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_switch_debouncer;

    logic       clk;
    logic       resetN;
    logic [2:0] swRaw;
    logic [2:0] swLevel;
    logic [2:0] swRise;
    logic [2:0] swFall;

    int tests_run;
    int tests_failed;

    switch_debouncer #(
        .NUM_SW          (3),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk     (clk),
        .resetN  (resetN),
        .swRaw   (swRaw),
        .swLevel (swLevel),
        .swRise  (swRise),
        .swFall  (swFall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        swRaw  = 3'b111;
        repeat (3) step();
        tests_run++;
        if ({swLevel, swRise, swFall} !== 9'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got lvl=%b rise=%b fall=%b, want all 0", swLevel, swRise, swFall);
        end
        // Release with only channel 0 held high.
        swRaw  = 3'b001;
        resetN = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step();
            tests_run++;
            if (swLevel !== ((e >= 7) ? 3'b001 : 3'b000) || swRise !== ((e == 7) ? 3'b001 : 3'b000) || swFall !== 3'b000) begin
                tests_failed++;
                $display("FAIL reset_release_edge%0d: got lvl=%b rise=%b fall=%b", e, swLevel, swRise, swFall);
            end
        end
    endtask

    task automatic test_glitch();
        swRaw[1] = 1'b1;
        repeat (3) step();
        swRaw[1] = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step();
            tests_run++;
            if (swLevel[1] !== 1'b0 || swRise[1] !== 1'b0 || swFall[1] !== 1'b0) begin
                tests_failed++;
                $display("FAIL glitch_ch1_edge%0d: got lvl=%b rise=%b fall=%b, want 0", e, swLevel[1], swRise[1], swFall[1]);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pattern;
        pattern  = 5'b10101;
        swRaw[0] = 1'b0;
        repeat (10) step();
        tests_run++;
        if (swLevel[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL bounce_setup_low: got lvl0=%b, want 0", swLevel[0]);
        end
        // Raw 1,0,1,0,1 sampled on edges 1..5, then held high: accept on edge 11.
        for (int e = 1; e <= 14; e++) begin
            swRaw[0] = (e <= 5) ? pattern[e-1] : 1'b1;
            step();
            tests_run++;
            if (swLevel[0] !== (e >= 11) || swRise[0] !== (e == 11) || swFall[0] !== 1'b0) begin
                tests_failed++;
                $display("FAIL bounce_ch0_edge%0d: got lvl=%b rise=%b fall=%b", e, swLevel[0], swRise[0], swFall[0]);
            end
        end
    endtask

    task automatic test_fall();
        swRaw[2] = 1'b1;
        repeat (10) step();
        tests_run++;
        if (swLevel[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL fall_setup_high: got lvl2=%b, want 1", swLevel[2]);
        end
        swRaw[2] = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            step();
            tests_run++;
            if (swLevel[2] !== (e < 7) || swFall[2] !== (e == 7) || swRise[2] !== 1'b0) begin
                tests_failed++;
                $display("FAIL fall_ch2_edge%0d: got lvl=%b rise=%b fall=%b", e, swLevel[2], swRise[2], swFall[2]);
            end
        end
    endtask

    task automatic test_simultaneous();
        swRaw = 3'b000;
        repeat (10) step();
        tests_run++;
        if (swLevel !== 3'b000) begin
            tests_failed++;
            $display("FAIL simul_setup: got lvl=%b, want 000", swLevel);
        end
        swRaw = 3'b101;
        for (int e = 1; e <= 9; e++) begin
            step();
            tests_run++;
            if (swLevel !== ((e >= 7) ? 3'b101 : 3'b000) || swRise !== ((e == 7) ? 3'b101 : 3'b000) || swFall !== 3'b000) begin
                tests_failed++;
                $display("FAIL simul_edge%0d: got lvl=%b rise=%b fall=%b", e, swLevel, swRise, swFall);
            end
        end
    endtask

    task automatic test_reset_mid_pend();
        swRaw = 3'b100;
        repeat (10) step();
        tests_run++;
        if (swLevel !== 3'b100) begin
            tests_failed++;
            $display("FAIL midreset_setup: got lvl=%b, want 100", swLevel);
        end
        // Channel 0 enters PEND_HI on edge 3; edge 4 leaves it two cycles in.
        swRaw = 3'b101;
        repeat (4) step();
        #3;
        resetN = 1'b0;
        #1;
        tests_run++;
        if ({swLevel, swRise, swFall} !== 9'b0) begin
            tests_failed++;
            $display("FAIL midreset_async: got lvl=%b rise=%b fall=%b, want all 0", swLevel, swRise, swFall);
        end
        step();
        step();
        resetN = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            tests_run++;
            if (swLevel !== ((e >= 7) ? 3'b101 : 3'b000) || swRise !== ((e == 7) ? 3'b101 : 3'b000) || swFall !== 3'b000) begin
                tests_failed++;
                $display("FAIL midreset_restart_edge%0d: got lvl=%b rise=%b fall=%b", e, swLevel, swRise, swFall);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        resetN       = 1'b0;
        swRaw        = 3'b000;
        test_reset();
        test_glitch();
        test_bounce();
        test_fall();
        test_simultaneous();
        test_reset_mid_pend();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
